adder_result_collector: RTL and testbench

- Receiving end of the final adder-tree stage in the CNN datapath.
- Samples the 19-bit signed sum whenever the stage's done strobe is high, adds a per-channel bias, rescales by an arithmetic right shift, applies optional ReLU and saturates to a 16-bit activation.
- Results are buffered in a small FIFO and presented on a valid/ready stream with a frame-last tag for the pooling/writeback stage.

---
 rtl/adder_result_collector.sv | 176 +++++++++++++++++
 tb/tb_adder_result_collector.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : adder_result_collector
// Description : Collects final adder-tree sums: bias add, arithmetic rescale,
//               optional ReLU, saturation to OUT_W, then a small FIFO with a
//               valid/ready output stream and a frame-last tag.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_result_collector #(
    parameter int IN_W      = 19,
    parameter int OUT_W     = 16,
    parameter int SHIFT     = 3,
    parameter int RELU_EN   = 1,
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [IN_W-1:0]            in_data,
    input  logic                       in_done,
    input  logic [OUT_W-1:0]           bias,
    input  logic                       clr,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [FC_W-1:0]         FRAME_LAST = FC_W'(FRAME_LEN - 1);
    localparam logic [AW:0]             FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic signed [IN_W:0]    SAT_MAX    = (IN_W + 1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [IN_W:0]    SAT_MIN    = (IN_W + 1)'(-(2 ** (OUT_W - 1)));
    localparam logic [OUT_W-1:0]        OUT_MAX    = OUT_W'(2 ** (OUT_W - 1) - 1);
    localparam logic [OUT_W-1:0]        OUT_MIN    = OUT_W'(2 ** (OUT_W - 1));

    // Stage 1: biased sum, one bit wider than the input so it cannot overflow
    logic signed [IN_W:0]  s1_q,        s1_d;
    logic                  v1_q,        v1_d;
    logic                  last1_q,     last1_d;
    logic [FC_W-1:0]       frame_cnt_q, frame_cnt_d;

    // Stage 2: rescaled and saturated activation
    logic [OUT_W-1:0]      res2_q,      res2_d;
    logic                  v2_q,        v2_d;
    logic                  last2_q,     last2_d;
    logic signed [IN_W:0]  t_w;

    // FIFO storage: {last, data} per entry
    logic [OUT_W:0]        mem_q [DEPTH];
    logic [OUT_W:0]        mem_d [DEPTH];
    logic [AW-1:0]         wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q,    rd_ptr_d;
    logic [AW:0]           count_q,     count_d;
    logic                  overflow_q,  overflow_d;

    logic                  pop_w;
    logic                  full_w;
    logic                  push_ok_w;
    logic [OUT_W:0]        head_w;

    // Stage 1: sample the sum on every done strobe and advance the frame index
    always_comb begin
        s1_d        = s1_q;
        v1_d        = 1'b0;
        last1_d     = last1_q;
        frame_cnt_d = frame_cnt_q;
        if (clr) begin
            frame_cnt_d = '0;
        end else if (in_done) begin
            s1_d        = {in_data[IN_W-1], in_data}
                        + {{(IN_W + 1 - OUT_W){bias[OUT_W-1]}}, bias};
            v1_d        = 1'b1;
            last1_d     = (frame_cnt_q == FRAME_LAST);
            frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + FC_W'(1);
        end
    end

    assign t_w = s1_q >>> SHIFT;

    // Stage 2: clamp the rescaled value into the signed OUT_W range
    always_comb begin
        res2_d  = t_w[OUT_W-1:0];
        v2_d    = v1_q & ~clr;
        last2_d = last1_q;
        if ((RELU_EN != 0) && t_w[IN_W]) begin
            res2_d = '0;
        end else if (t_w > SAT_MAX) begin
            res2_d = OUT_MAX;
        end else if (t_w < SAT_MIN) begin
            res2_d = OUT_MIN;
        end
    end

    assign pop_w     = (count_q != '0) && out_ready;
    assign full_w    = (count_q == FULL_CNT);
    assign push_ok_w = v2_q && (!full_w || pop_w);

    // FIFO: write when room (or a pop frees a slot this edge), else flag a drop
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok_w) begin
                mem_d[wr_ptr_q] = {last2_q, res2_q};
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (v2_q && !push_ok_w) begin
                overflow_d = 1'b1;
            end
            if (push_ok_w && !pop_w) begin
                count_d = count_q + (AW + 1)'(1);
            end else if (!push_ok_w && pop_w) begin
                count_d = count_q - (AW + 1)'(1);
            end
        end
    end

    // State registers for pipeline, frame counter and FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            v1_q        <= 1'b0;
            last1_q     <= 1'b0;
            frame_cnt_q <= '0;
            res2_q      <= '0;
            v2_q        <= 1'b0;
            last2_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            v1_q        <= v1_d;
            last1_q     <= last1_d;
            frame_cnt_q <= frame_cnt_d;
            res2_q      <= res2_d;
            v2_q        <= v2_d;
            last2_q     <= last2_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign head_w    = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? head_w[OUT_W-1:0] : '0;
    assign out_last  = out_valid & head_w[OUT_W];
    assign overflow  = overflow_q;
    assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_result_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_adder_result_collector
// Description : Self-checking bench; two collector instances (ReLU with
//               4-result frames, signed saturation with 16-result frames).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_result_collector;

    localparam int DEPTH = 4;
    localparam int SHIFT = 3;
    localparam int FL_A  = 4;
    localparam int FL_B  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [18:0] in_data;
    logic        in_done;
    logic [15:0] bias;
    logic        clr;
    logic        out_ready;

    logic [15:0] out_data_a, out_data_b;
    logic        out_valid_a, out_valid_b;
    logic        out_last_a, out_last_b;
    logic        overflow_a, overflow_b;
    logic [2:0]  count_a, count_b;

    always #5 clk = ~clk;

    adder_result_collector #(
        .IN_W(19), .OUT_W(16), .SHIFT(SHIFT), .RELU_EN(1), .DEPTH(DEPTH), .FRAME_LEN(FL_A)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_done(in_done), .bias(bias),
        .clr(clr), .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_last(out_last_a), .overflow(overflow_a), .count(count_a)
    );

    adder_result_collector #(
        .IN_W(19), .OUT_W(16), .SHIFT(SHIFT), .RELU_EN(0), .DEPTH(DEPTH), .FRAME_LEN(FL_B)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_done(in_done), .bias(bias),
        .clr(clr), .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_last(out_last_b), .overflow(overflow_b), .count(count_b)
    );

    // Reference model: results travel as items due two edges after sampling
    typedef struct {
        int          due;
        logic [15:0] da;
        logic [15:0] db;
        bit          la;
        bit          lb;
    } item_t;

    item_t pend[$];
    item_t fifo[$];
    int    edge_n = 0;
    int    fa = 0;
    int    fb = 0;
    bit    ovf = 1'b0;
    int    checks = 0;
    int    failures = 0;

    function automatic logic [15:0] ref_act(input logic [18:0] x, input logic [15:0] b,
                                            input bit relu);
        longint s;
        longint t;
        s = longint'($signed(x)) + longint'($signed(b));
        t = s >>> SHIFT;
        if (relu && t < 0)  t = 0;
        if (t > 32767)      t = 32767;
        if (t < -32768)     t = -32768;
        return t[15:0];
    endfunction

    task automatic model_clear();
        pend.delete();
        fifo.delete();
        fa  = 0;
        fb  = 0;
        ovf = 1'b0;
    endtask

    task automatic model_edge();
        item_t it;
        bit    have;
        bit    pop;
        if (clr) begin
            model_clear();
        end else begin
            pop  = (fifo.size() != 0) && out_ready;
            have = 1'b0;
            if (pend.size() != 0 && pend[0].due == edge_n) begin
                it   = pend.pop_front();
                have = 1'b1;
            end
            if (pop) void'(fifo.pop_front());
            if (have) begin
                if (fifo.size() < DEPTH) fifo.push_back(it);
                else                     ovf = 1'b1;
            end
            if (in_done) begin
                it.due = edge_n + 2;
                it.da  = ref_act(in_data, bias, 1'b1);
                it.db  = ref_act(in_data, bias, 1'b0);
                it.la  = (fa == FL_A - 1);
                it.lb  = (fb == FL_B - 1);
                fa     = (fa + 1) % FL_A;
                fb     = (fb + 1) % FL_B;
                pend.push_back(it);
            end
        end
        edge_n++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        bit          ev;
        logic [15:0] eda, edb;
        bit          ela, elb;
        ev  = (fifo.size() != 0);
        eda = ev ? fifo[0].da : 16'h0;
        edb = ev ? fifo[0].db : 16'h0;
        ela = ev ? fifo[0].la : 1'b0;
        elb = ev ? fifo[0].lb : 1'b0;
        chk("a_valid", 32'(out_valid_a), 32'(ev));
        chk("b_valid", 32'(out_valid_b), 32'(ev));
        chk("a_data",  32'(out_data_a),  32'(eda));
        chk("b_data",  32'(out_data_b),  32'(edb));
        chk("a_last",  32'(out_last_a),  32'(ela));
        chk("b_last",  32'(out_last_b),  32'(elb));
        chk("a_ovf",   32'(overflow_a),  32'(ovf));
        chk("b_ovf",   32'(overflow_b),  32'(ovf));
        chk("a_count", 32'(count_a),     32'(fifo.size()));
        chk("b_count", 32'(count_b),     32'(fifo.size()));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // One strobe with an empty FIFO and out_ready=1; head checked after 3 edges
    task automatic single(input int x, input int b, input logic [15:0] ea,
                          input logic [15:0] eb);
        in_data = 19'(x);
        bias    = 16'(b);
        in_done = 1'b1;
        step();
        in_done = 1'b0;
        step();
        step();
        chk("single_valid", 32'(out_valid_a), 32'd1);
        chk("single_a", 32'(out_data_a), 32'(ea));
        chk("single_b", 32'(out_data_b), 32'(eb));
        step();
    endtask

    // Strobes then idle cycles; tallies dut_a outputs and which were tagged last
    task automatic run_cycles(input int ns, input int ni, output int n,
                              output logic [31:0] mask);
        n    = 0;
        mask = '0;
        for (int i = 0; i < ns + ni; i++) begin
            in_done = (i < ns);
            in_data = 19'(8 * (i + 1));
            step();
            if (out_valid_a) begin
                n++;
                if (out_last_a) mask[n] = 1'b1;
            end
        end
        in_done = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        int          n;
        logic [31:0] mask;

        rst_n     = 1'b0;
        in_data   = '0;
        in_done   = 1'b0;
        bias      = '0;
        clr       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        compare_all();
        rst_n = 1'b1;

        // Datapath arithmetic and saturation corners
        single(800, 0, 16'd100, 16'd100);
        single(-80, 0, 16'h0000, 16'hFFF6);
        single(262143, 8, 16'h7FFF, 16'h7FFF);
        single(262143, 16, 16'h7FFF, 16'h7FFF);
        single(-262144, -16, 16'h0000, 16'h8000);
        single(8, 8, 16'd2, 16'd2);

        // Frame-last tagging
        bias = '0;
        do_clr();
        run_cycles(10, 3, n, mask);
        chk("frame_count", 32'(n), 32'd10);
        chk("frame_lastmask", mask, 32'h0000_0110);
        do_clr();
        run_cycles(4, 3, n, mask);
        chk("frame_after_clr", mask, 32'h0000_0010);

        // Overflow with the consumer stalled
        do_clr();
        out_ready = 1'b0;
        run_cycles(6, 2, n, mask);
        chk("ovf_count", 32'(count_a), 32'd4);
        chk("ovf_flag", 32'(overflow_a), 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_head", 32'(out_data_a), 32'(i));
            step();
        end
        chk("ovf_drained", 32'(count_a), 32'd0);
        chk("ovf_sticky", 32'(overflow_a), 32'd1);
        do_clr();
        chk("ovf_cleared", 32'(overflow_a), 32'd0);

        // Full FIFO at full rate: push and pop together never drop
        out_ready = 1'b0;
        in_done   = 1'b1;
        in_data   = 19'd40;
        repeat (6) step();
        chk("full_count", 32'(count_a), 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 19'(16 * i);
            step();
            chk("full_rate_count", 32'(count_a), 32'd4);
            chk("full_rate_ovf", 32'(overflow_a), 32'd0);
        end
        in_done = 1'b0;
        repeat (6) step();

        // Asynchronous reset with 3 queued and 2 in flight
        do_clr();
        out_ready = 1'b0;
        run_cycles(5, 0, n, mask);
        chk("pre_reset_count", 32'(count_a), 32'd3);
        rst_n = 1'b0;
        #1;
        model_clear();
        compare_all();
        chk("reset_data", 32'(out_data_a), 32'd0);
        @(posedge clk);
        #1;
        compare_all();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        chk("post_reset_valid", 32'(out_valid_a), 32'd0);
        run_cycles(4, 3, n, mask);
        chk("post_reset_frame", mask, 32'h0000_0010);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            in_done   = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 1) == 1);
            in_data   = 19'($urandom);
            if (i % 32 == 0) bias = 16'($urandom);
            clr       = ($urandom_range(0, 49) == 0);
            step();
        end
        clr = 1'b0;
        in_done = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
